// File: rtl/mc_alu_controller_if.sv
// Control/status bundle between the multicycle controller and the shared ALU datapath.
// The datapath side (master) supplies instruction fields and ALU flags; the controller (slave) returns selects.
interface mc_alu_controller_if;
   logic [1:0] op;
   logic [3:0] funct;
   logic       alu_z;
   logic       alu_n;
   logic       alu_c;
   logic       alu_v;
   logic       ir_write;
   logic       pc_write;
   logic       adr_src;
   logic       mem_write;
   logic       reg_write;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_ctrl;
   logic [1:0] result_src;
   logic [3:0] flags;
   logic       illegal_op;
   logic [3:0] state;

   // No handshake: op/funct/alu_* are level signals; the controller samples them only in the states that use them.
   modport master (
      output op, funct, alu_z, alu_n, alu_c, alu_v,
      input  ir_write, pc_write, adr_src, mem_write, reg_write,
             alu_src_a, alu_src_b, alu_ctrl, result_src, flags, illegal_op, state
   );

   modport slave (
      input  op, funct, alu_z, alu_n, alu_c, alu_v,
      output ir_write, pc_write, adr_src, mem_write, reg_write,
             alu_src_a, alu_src_b, alu_ctrl, result_src, flags, illegal_op, state
   );
endinterface

// File: rtl/mc_alu_controller.sv
// Multicycle processor control FSM: sequences fetch/decode/execute/memory/writeback,
// holds the NZCV flag register and resolves branch conditions from the held flags.
module mc_alu_controller #(
   parameter int PC_INC = 4
) (
   input logic              clk,
   input logic              rst_n,
   mc_alu_controller_if.slave bus
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      EXEC_DP = 4'd2,
      ALU_WB  = 4'd3,
      MEM_ADR = 4'd4,
      MEM_RD  = 4'd5,
      MEM_WB  = 4'd6,
      MEM_WR  = 4'd7,
      BRANCH  = 4'd8
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [3:0] flags_q;
   logic [1:0] cond_q;
   logic       taken;

   // The increment itself lives in the datapath (operand-B select 2); a non-word step is legal but unusual.
   if (PC_INC != 4) begin : g_nonword_pc_inc
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         flags_q <= 4'b0000;
         cond_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         if (state_q == EXEC_DP && bus.funct[3])
            flags_q <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
         // Branch condition is captured in DECODE so funct may change once decode is done.
         if (state_q == DECODE)
            cond_q <= bus.funct[1:0];
      end
   end

   // flags_q is {N,Z,C,V}; only held flags feed the decision, never the live ALU flags.
   always_comb begin
      taken = 1'b0;
      case (cond_q)
         2'b00: taken = 1'b1;
         2'b01: taken = flags_q[2];
         2'b10: taken = !flags_q[2];
         2'b11: taken = flags_q[3] ^ flags_q[0];
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d        = FETCH;
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.adr_src    = 1'b0;
      bus.mem_write  = 1'b0;
      bus.reg_write  = 1'b0;
      bus.alu_src_a  = 2'd0;
      bus.alu_src_b  = 2'd0;
      bus.alu_ctrl   = 3'b000;
      bus.result_src = 2'd0;
      bus.illegal_op = 1'b0;
      case (state_q)
         FETCH: begin
            bus.ir_write   = 1'b1;
            bus.pc_write   = 1'b1;
            bus.alu_src_b  = 2'd2;
            bus.result_src = 2'd2;
            state_d        = DECODE;
         end
         DECODE: begin
            bus.alu_src_b = 2'd1;
            case (bus.op)
               2'b00:   state_d = EXEC_DP;
               2'b01:   state_d = MEM_ADR;
               2'b10:   state_d = BRANCH;
               default: begin
                  state_d        = FETCH;
                  bus.illegal_op = 1'b1;
               end
            endcase
         end
         EXEC_DP: begin
            bus.alu_src_a = 2'd1;
            bus.alu_ctrl  = bus.funct[2:0];
            state_d       = ALU_WB;
         end
         ALU_WB: begin
            bus.reg_write = 1'b1;
            state_d       = FETCH;
         end
         MEM_ADR: begin
            bus.alu_src_a = 2'd1;
            bus.alu_src_b = 2'd1;
            state_d       = bus.funct[0] ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            bus.adr_src = 1'b1;
            state_d     = MEM_WB;
         end
         MEM_WB: begin
            bus.result_src = 2'd1;
            bus.reg_write  = 1'b1;
            state_d        = FETCH;
         end
         MEM_WR: begin
            bus.adr_src   = 1'b1;
            bus.mem_write = 1'b1;
            state_d       = FETCH;
         end
         BRANCH: begin
            bus.pc_write = taken;
            state_d      = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   assign bus.flags = flags_q;
   assign bus.state = state_q;

endmodule

// File: tb/tb_mc_alu_controller.sv
// Directed bench for mc_alu_controller: an instruction-level model expands each instruction into
// its expected per-cycle outputs, which are compared against the DUT mid-cycle.
module tb_mc_alu_controller;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   mc_alu_controller_if bus ();

   mc_alu_controller #(.PC_INC(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected cycle record: {state, ir_write, pc_write, adr_src, mem_write, reg_write,
   //                         alu_src_a, alu_src_b, alu_ctrl, result_src, flags, illegal_op}
   localparam int W = 23;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] msk_q[$];
   logic [3:0]   mflags;

   function automatic logic [W-1:0] rec(input logic [3:0] st, input logic irw, input logic pcw,
                                        input logic adr, input logic mw, input logic rw,
                                        input logic [1:0] sa, input logic [1:0] sb,
                                        input logic [2:0] ac, input logic [1:0] rs,
                                        input logic [3:0] fl, input logic ill);
      return {st, irw, pcw, adr, mw, rw, sa, sb, ac, rs, fl, ill};
   endfunction

   function automatic logic [W-1:0] observed();
      return {bus.state, bus.ir_write, bus.pc_write, bus.adr_src, bus.mem_write, bus.reg_write,
              bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl, bus.result_src, bus.flags, bus.illegal_op};
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [W-1:0] r, input logic adr_dont_care);
      exp_q.push_back(r);
      msk_q.push_back(adr_dont_care ? ~(23'd1 << 16) : '1);
   endtask

   // Entered at posedge+2; compares at the negedge, returns at the next posedge+2.
   task automatic cyc();
      logic [W-1:0] e;
      logic [W-1:0] m;
      @(negedge clk);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         m = msk_q.pop_front();
         chk($sformatf("cycle state=%0d", e[22:19]), observed() & m, e & m);
      end
      @(posedge clk);
      #2;
   endtask

   task automatic push_front_end(input logic [1:0] op);
      push(rec(4'd0, 1, 1, 0, 0, 0, 2'd0, 2'd2, 3'd0, 2'd2, mflags, 0), 0);
      push(rec(4'd1, 0, 0, 0, 0, 0, 2'd0, 2'd1, 3'd0, 2'd0, mflags, op == 2'b11), 0);
   endtask

   // Instruction-level model: expands one instruction into its cycle records, then steps through them.
   task automatic run_instr(input logic [1:0] op, input logic [3:0] funct, input logic n,
                            input logic z, input logic c, input logic v);
      logic tk;
      bus.op    = op;
      bus.funct = funct;
      bus.alu_n = n;
      bus.alu_z = z;
      bus.alu_c = c;
      bus.alu_v = v;
      push_front_end(op);
      case (op)
         2'b00: begin
            push(rec(4'd2, 0, 0, 0, 0, 0, 2'd1, 2'd0, funct[2:0], 2'd0, mflags, 0), 0);
            if (funct[3]) mflags = {n, z, c, v};
            push(rec(4'd3, 0, 0, 0, 0, 1, 2'd0, 2'd0, 3'd0, 2'd0, mflags, 0), 0);
         end
         2'b01: begin
            push(rec(4'd4, 0, 0, 0, 0, 0, 2'd1, 2'd1, 3'd0, 2'd0, mflags, 0), 0);
            if (funct[0]) begin
               push(rec(4'd5, 0, 0, 1, 0, 0, 2'd0, 2'd0, 3'd0, 2'd0, mflags, 0), 0);
               push(rec(4'd6, 0, 0, 0, 0, 1, 2'd0, 2'd0, 3'd0, 2'd1, mflags, 0), 1);
            end else begin
               push(rec(4'd7, 0, 0, 1, 1, 0, 2'd0, 2'd0, 3'd0, 2'd0, mflags, 0), 0);
            end
         end
         2'b10: begin
            case (funct[1:0])
               2'b00:   tk = 1'b1;
               2'b01:   tk = mflags[2];
               2'b10:   tk = !mflags[2];
               default: tk = mflags[3] != mflags[0];
            endcase
            push(rec(4'd8, 0, tk, 0, 0, 0, 2'd0, 2'd0, 3'd0, 2'd0, mflags, 0), 0);
         end
         default: ;
      endcase
      while (exp_q.size() > 0) cyc();
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      mflags  = 4'b0000;
      rst_n   = 1'b0;
      bus.op    = 2'b00;
      bus.funct = 4'b0000;
      bus.alu_n = 1'b0;
      bus.alu_z = 1'b0;
      bus.alu_c = 1'b0;
      bus.alu_v = 1'b0;

      #3;
      chk("reset outputs", observed(), rec(4'd0, 1, 1, 0, 0, 0, 2'd0, 2'd2, 3'd0, 2'd2, 4'd0, 0));
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // SUB with S=1, Z from ALU -> flags 0100
      run_instr(2'b00, 4'b1001, 0, 1, 0, 0);
      chk("flags after SUBS", {19'd0, bus.flags}, {19'd0, 4'b0100});
      run_instr(2'b01, 4'b0001, 1, 1, 1, 1);
      run_instr(2'b01, 4'b0000, 0, 0, 0, 0);
      run_instr(2'b10, 4'b0001, 0, 0, 0, 0);
      run_instr(2'b10, 4'b0010, 0, 0, 0, 0);
      // N=1, V=0 -> LT taken, EQ not taken
      run_instr(2'b00, 4'b1000, 1, 0, 0, 0);
      run_instr(2'b10, 4'b0011, 0, 0, 0, 0);
      run_instr(2'b10, 4'b0001, 0, 0, 0, 0);
      // S=0 with all ALU flags high leaves flags alone
      run_instr(2'b00, 4'b0110, 1, 1, 1, 1);
      chk("flags after S=0", {19'd0, bus.flags}, {19'd0, 4'b1000});
      run_instr(2'b11, 4'b0000, 0, 0, 0, 0);
      run_instr(2'b10, 4'b0000, 0, 0, 0, 0);
      run_instr(2'b00, 4'b1111, 0, 1, 1, 1);

      // Store aborted by reset while in MEM_WR
      bus.op    = 2'b01;
      bus.funct = 4'b0000;
      push_front_end(2'b01);
      push(rec(4'd4, 0, 0, 0, 0, 0, 2'd1, 2'd1, 3'd0, 2'd0, mflags, 0), 0);
      while (exp_q.size() > 0) cyc();
      chk("in MEM_WR before abort", {18'd0, bus.state, bus.mem_write}, {18'd0, 4'd7, 1'b1});
      rst_n = 1'b0;
      #1;
      mflags = 4'b0000;
      chk("async reset mid-store", observed(), rec(4'd0, 1, 1, 0, 0, 0, 2'd0, 2'd2, 3'd0, 2'd2, 4'd0, 0));
      @(posedge clk);
      #1;
      chk("held in reset", observed(), rec(4'd0, 1, 1, 0, 0, 0, 2'd0, 2'd2, 3'd0, 2'd2, 4'd0, 0));
      #1;
      rst_n = 1'b1;

      run_instr(2'b00, 4'b1010, 0, 0, 1, 0);
      chk("flags after recovery", {19'd0, bus.flags}, {19'd0, 4'b0010});
      run_instr(2'b10, 4'b0010, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
